// File: rtl/axi4lite_pkg.sv
// Shared constants and types for the AXI4-Lite master/slave pair.
package axi4lite_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } state_t;

endpackage

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave: register file with single-outstanding write and read responses.
module axi4lite_slave_regs
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  awvalid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awready,
    input  logic                  wvalid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wready,
    output logic                  bvalid,
    output logic [1:0]            bresp,
    input  logic                  bready,
    input  logic                  arvalid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    input  logic                  rready
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // Address and data are accepted together, and only once the previous response has drained.
    assign awready = awvalid & wvalid & ~bvalid;
    assign wready  = awready;
    assign arready = ~rvalid;
    assign bresp   = RESP_OKAY;
    assign rresp   = RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            if (awvalid && awready) begin
                regs[awaddr] <= wdata;
                bvalid       <= 1'b1;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end

            if (arvalid && arready) begin
                rdata  <= regs[araddr];
                rvalid <= 1'b1;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi4lite_top.sv
// Pin-level wrapper: start strobes drive an AXI4-Lite master FSM into the slave register file.
module axi4lite_top
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  done;
    logic                  busy;
    logic                  last_op_read;
    logic                  oe;

    logic                  awvalid, awready, wvalid, wready, bvalid, bready;
    logic                  arvalid, arready, rvalid, rready;
    logic [1:0]            bresp, rresp;
    logic [DATA_WIDTH-1:0] rdata;

    logic start_write, start_read;
    assign start_write = ui_in[0];
    assign start_read  = ui_in[4];

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[7:5], bresp, rresp};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr         <= '0;
            data         <= '0;
            read_data    <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            last_op_read <= 1'b0;
            oe           <= 1'b0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Write has priority; the two addresses overlap on ui_in[2].
                    if (start_write) begin
                        addr    <= ui_in[2:1];
                        data    <= uio_in;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_WADDR;
                    end else if (start_read) begin
                        addr    <= ui_in[3:2];
                        arvalid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_RADDR;
                    end
                end
                ST_WADDR: if (awready && wready) begin
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    bready  <= 1'b1;
                    state   <= ST_WRESP;
                end
                ST_WRESP: if (bvalid) begin
                    bready       <= 1'b0;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    oe           <= 1'b0;
                    last_op_read <= 1'b0;
                    state        <= ST_IDLE;
                end
                ST_RADDR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= ST_RDATA;
                end
                ST_RDATA: if (rvalid) begin
                    rready       <= 1'b0;
                    read_data    <= rdata;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    oe           <= 1'b1;
                    last_op_read <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axi4lite_slave_regs #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_slave (
        .clk     (clk),
        .rst     (rst),
        .awvalid (awvalid),
        .awaddr  (addr),
        .awready (awready),
        .wvalid  (wvalid),
        .wdata   (data),
        .wready  (wready),
        .bvalid  (bvalid),
        .bresp   (bresp),
        .bready  (bready),
        .arvalid (arvalid),
        .araddr  (addr),
        .arready (arready),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rready  (rready)
    );

    assign uo_out  = {5'b0, last_op_read, busy, done};
    assign uio_out = read_data;
    assign uio_oe  = {8{oe}};

endmodule

// File: tb/tb_axi4lite_top.sv
// Bench for axi4lite_top: vector table, hand-written corner sequences and randomized traffic vs. a register model.
module tb_axi4lite_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    axi4lite_top #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: four bytes of storage plus the externally visible read-side state.
    logic [7:0] mem [4];
    logic [7:0] m_rd;
    logic       m_oe;
    logic       m_last;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] data;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
        logic [7:0] exp_oe;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        m_rd   = 8'h00;
        m_oe   = 1'b0;
        m_last = 1'b0;
    endtask

    task automatic model_apply(input logic [7:0] ui, input logic [7:0] d);
        if (ui[0]) begin
            mem[ui[2:1]] = d;
            m_last = 1'b0;
            m_oe   = 1'b0;
        end else if (ui[4]) begin
            m_rd   = mem[ui[3:2]];
            m_last = 1'b1;
            m_oe   = 1'b1;
        end
    endtask

    // Launch one transaction, check busy and done latency, and return the outputs in the done cycle.
    task automatic txn(input string name, input logic [7:0] ui, input logic [7:0] d,
                       output logic [7:0] uo, output logic [7:0] uio, output logic [7:0] oe);
        int lat = 0;
        @(negedge clk);
        ui_in  = ui;
        uio_in = d;
        ena    = 1'($urandom_range(0, 1));
        @(negedge clk);
        ui_in  = 8'($urandom) & 8'hE0;
        uio_in = 8'($urandom);
        for (int k = 1; k <= 8; k++) begin
            if (uo_out[0]) begin
                lat = k;
                break;
            end
            check({name, " busy"}, {7'b0, uo_out[1]}, 8'h01);
            @(negedge clk);
        end
        check({name, " latency"}, 8'(lat), 8'd3);
        uo  = uo_out;
        uio = uio_out;
        oe  = uio_oe;
        @(negedge clk);
        check({name, " done width"}, {7'b0, uo_out[0]}, 8'h00);
    endtask

    logic [7:0] got_uo, got_uio, got_oe;
    logic [7:0] rui, rdat;
    int         pulses;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vecs[0]  = '{8'h05, 8'h04, 8'h01, 8'h00, 8'h00};
        vecs[1]  = '{8'h18, 8'h00, 8'h05, 8'h04, 8'hFF};
        vecs[2]  = '{8'h01, 8'h11, 8'h01, 8'h04, 8'h00};
        vecs[3]  = '{8'h03, 8'h22, 8'h01, 8'h04, 8'h00};
        vecs[4]  = '{8'h05, 8'h33, 8'h01, 8'h04, 8'h00};
        vecs[5]  = '{8'h07, 8'h44, 8'h01, 8'h04, 8'h00};
        vecs[6]  = '{8'h10, 8'h00, 8'h05, 8'h11, 8'hFF};
        vecs[7]  = '{8'h14, 8'h00, 8'h05, 8'h22, 8'hFF};
        vecs[8]  = '{8'h18, 8'h00, 8'h05, 8'h33, 8'hFF};
        vecs[9]  = '{8'h1C, 8'h00, 8'h05, 8'h44, 8'hFF};
        vecs[10] = '{8'h13, 8'h5A, 8'h01, 8'h44, 8'h00};
        vecs[11] = '{8'h14, 8'h00, 8'h05, 8'h5A, 8'hFF};

        rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("reset uio_oe", uio_oe, 8'h00);

        for (int a = 0; a < 4; a++) begin
            rui = 8'h10 | 8'(a << 2);
            txn("reset readback", rui, 8'h00, got_uo, got_uio, got_oe);
            model_apply(rui, 8'h00);
            check("reset readback data", got_uio, 8'h00);
        end

        // Start from zeroed state so the table's expected values apply.
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        model_reset();

        for (int i = 0; i < 12; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].ui, vecs[i].data, got_uo, got_uio, got_oe);
            model_apply(vecs[i].ui, vecs[i].data);
            check($sformatf("vec%0d uo_out", i), got_uo, vecs[i].exp_uo);
            check($sformatf("vec%0d uio_out", i), got_uio, vecs[i].exp_uio);
            check($sformatf("vec%0d uio_oe", i), got_oe, vecs[i].exp_oe);
        end

        // Starts held while busy must be ignored.
        @(negedge clk); ui_in = 8'h07; uio_in = 8'h77;
        @(negedge clk); ui_in = 8'h17; uio_in = 8'h99;
        pulses = 0;
        @(negedge clk); pulses += int'(uo_out[0]);
        @(negedge clk); ui_in = 8'h00; pulses += int'(uo_out[0]);
        repeat (5) begin @(negedge clk); pulses += int'(uo_out[0]); end
        check("busy-ignore done pulses", 8'(pulses), 8'd1);
        model_apply(8'h07, 8'h77);
        txn("busy-ignore readback", 8'h1C, 8'h00, got_uo, got_uio, got_oe);
        model_apply(8'h1C, 8'h00);
        check("busy-ignore data", got_uio, 8'h77);

        // Reset sampled on the WADDR->WRESP edge of a write.
        @(negedge clk); ui_in = 8'h03; uio_in = 8'hC3;
        @(negedge clk); ui_in = 8'h00; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        check("mid-reset uo_out", uo_out, 8'h00);
        check("mid-reset uio_oe", uio_oe, 8'h00);
        check("mid-reset uio_out", uio_out, 8'h00);
        pulses = 0;
        repeat (4) begin @(negedge clk); pulses += int'(uo_out[0]); end
        check("mid-reset no done", 8'(pulses), 8'd0);
        txn("mid-reset readback", 8'h14, 8'h00, got_uo, got_uio, got_oe);
        model_apply(8'h14, 8'h00);
        check("mid-reset readback data", got_uio, 8'h00);

        for (int n = 0; n < 40; n++) begin
            rdat = 8'($urandom);
            rui  = 8'($urandom) & 8'hEE;
            case ($urandom_range(0, 2))
                0:       rui = rui | 8'h01;
                1:       rui = rui | 8'h10;
                default: rui = rui | 8'h11;
            endcase
            txn($sformatf("rand%0d", n), rui, rdat, got_uo, got_uio, got_oe);
            model_apply(rui, rdat);
            check($sformatf("rand%0d uo_out", n), got_uo, {5'b0, m_last, 1'b0, 1'b1});
            check($sformatf("rand%0d uio_out", n), got_uio, m_rd);
            check($sformatf("rand%0d uio_oe", n), got_oe, {8{m_oe}});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
